// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: ping-pong input stage for the FFT. It takes samples
// in natural order and replays each frame to the FFT in bit-reversed order.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   s_valid_i/s_re_i/s_im_i      sample stream in (natural order)
//   s_ready_o                    stream ready (current write bank empty)
//   fft_ready_i                  FFT result-phase flag; its fall = FFT idle
//   start_o, x_re_o, x_im_o      N-cycle load burst to the FFT
//   frame_cnt_o                  frames launched, wraps at 2^16
module fft_bitrev_loader #(
    parameter int N  = 128,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid_i,
    input  logic [DW-1:0] s_re_i,
    input  logic [DW-1:0] s_im_i,
    output logic          s_ready_o,
    input  logic          fft_ready_i,
    output logic          start_o,
    output logic [DW-1:0] x_re_o,
    output logic [DW-1:0] x_im_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_DRAIN} bank_t;
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} rd_t;

    bank_t           bank_st [2];
    logic [2*DW-1:0] mem [2][N];

    logic            wr_bank;
    logic [AW-1:0]   wr_idx;
    logic            accept;
    logic            wr_last;

    rd_t             st;
    rd_t             st_nxt;
    logic            rd_bank;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_word;
    logic            rd_last;
    logic            claim;
    logic            launch;
    logic            advance;
    logic            drain_done;

    logic            fft_idle;
    logic            ready_q;
    logic            ready_fall;

    logic            start_q;
    logic [DW-1:0]   x_re_q;
    logic [DW-1:0]   x_im_q;
    logic [15:0]     frame_cnt_q;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // ---------------- write side ----------------
    assign s_ready_o = (bank_st[wr_bank] == B_EMPTY);
    assign accept    = s_valid_i && s_ready_o;
    assign wr_last   = accept && (wr_idx == AW'(N-1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (accept) begin
            // N is a power of two, so the index wraps to 0 by itself
            wr_idx <= wr_idx + 1'b1;
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // storage has no reset; bank state alone decides what is valid
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][bitrev(wr_idx)] <= {s_re_i, s_im_i};
        end
    end

    // a fill only touches an EMPTY bank and claim/drain only a FULL/DRAIN
    // one, so the writer and reader never update the same bank together
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && wr_bank == 1'(b)) begin
                    bank_st[b] <= B_FULL;
                end else if (claim && rd_bank == 1'(b)) begin
                    bank_st[b] <= B_DRAIN;
                end else if (drain_done && rd_bank == 1'(b)) begin
                    bank_st[b] <= B_EMPTY;
                end
            end
        end
    end

    // ---------------- FFT idle tracking ----------------
    assign ready_fall = ready_q && !fft_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fft_idle <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= fft_ready_i;
            if (launch) begin
                fft_idle <= 1'b0;
            end else if (ready_fall) begin
                fft_idle <= 1'b1;
            end
        end
    end

    // ---------------- read FSM ----------------
    assign rd_last = (rd_idx == AW'(N-1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st <= S_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        unique case (1'b1)
            (st == S_IDLE): begin
                if (bank_st[rd_bank] == B_FULL && fft_idle) begin
                    st_nxt = S_PRIME;
                end
            end
            (st == S_PRIME): begin
                st_nxt = S_STREAM;
            end
            (st == S_STREAM): begin
                if (rd_last) begin
                    st_nxt = S_IDLE;
                end
            end
            default: begin
                st_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        claim      = (st == S_IDLE) && (st_nxt == S_PRIME);
        launch     = (st == S_PRIME);
        advance    = (st == S_STREAM) && !rd_last;
        drain_done = (st == S_STREAM) && rd_last;
        // PRIME fetches word 0; each stream cycle fetches the next word
        rd_addr    = launch ? '0 : rd_idx + 1'b1;
    end

    assign rd_word = mem[rd_bank][rd_addr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q     <= 1'b0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            rd_idx      <= '0;
            rd_bank     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (launch || advance) begin
                x_re_q <= rd_word[2*DW-1:DW];
                x_im_q <= rd_word[DW-1:0];
            end
            if (launch) begin
                start_q <= 1'b1;
                rd_idx  <= '0;
            end else if (advance) begin
                rd_idx <= rd_idx + 1'b1;
            end else if (drain_done) begin
                start_q     <= 1'b0;
                rd_idx      <= '0;
                rd_bank     <= ~rd_bank;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign start_o     = start_q;
    assign x_re_o      = x_re_q;
    assign x_im_o      = x_im_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Bench for fft_bitrev_loader (N=8): frame-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_fft_bitrev_loader;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_re_i = '0;
    logic [DW-1:0] s_im_i = '0;
    logic          s_ready_o;
    logic          fft_ready_i = 1'b0;
    logic          start_o;
    logic [DW-1:0] x_re_o;
    logic [DW-1:0] x_im_o;
    logic [15:0]   frame_cnt_o;

    fft_bitrev_loader #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid_i  (s_valid_i),
        .s_re_i     (s_re_i),
        .s_im_i     (s_im_i),
        .s_ready_o  (s_ready_o),
        .fft_ready_i(fft_ready_i),
        .start_o    (start_o),
        .x_re_o     (x_re_o),
        .x_im_o     (x_im_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + ((k >> b) & 1);
        end
        return r;
    endfunction

    // frame-level model
    logic [2*DW-1:0] part[$];
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] w;
    int              run = 0;
    int              bursts = 0;
    int              last_acc = 0;
    int              rise_cyc = 0;
    logic [15:0]     cnt_base = '0;
    logic [15:0]     ecnt;
    logic [DW-1:0]   last_re [N];

    always @(negedge clk) begin
        if (!rstn) begin
            part.delete();
            exp_q.delete();
            run    = 0;
            bursts = 0;
        end else begin
            if (start_o) begin
                if (run == 0) rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL burst_underflow: start_o high, model has no data");
                end else begin
                    w = exp_q.pop_front();
                    chk("x_re", x_re_o, w[2*DW-1:DW]);
                    chk("x_im", x_im_o, w[DW-1:0]);
                end
                if (run < N) last_re[run] = x_re_o;
                run++;
            end else if (run != 0) begin
                chk("burst_len", run, N);
                bursts++;
                run  = 0;
                ecnt = cnt_base + bursts[15:0];
                chk("frame_cnt", frame_cnt_o, ecnt);
            end
            if (s_valid_i && s_ready_o) begin
                part.push_back({s_re_i, s_im_i});
                last_acc = cyc + 1;
                if (part.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        exp_q.push_back(part[brev(k)]);
                    end
                    part.delete();
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        logic ok;
        int   k;
        s_valid_i = 1'b1;
        s_re_i    = re;
        s_im_i    = im;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 300) begin
            @(negedge clk);
            ok = s_ready_o;
            k++;
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready_o 0 for %0d cycles", k);
        end
    endtask

    task automatic wait_bursts(input int target);
        int k = 0;
        while (bursts < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bursts < target) begin
            errors++;
            $display("FAIL wait_bursts: got %0d want %0d", bursts, target);
        end
        tick(1);
    endtask

    task automatic pulse_ready(output int fc);
        fft_ready_i = 1'b1;
        tick(2);
        fft_ready_i = 1'b0;
        fc = cyc;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        s_valid_i   = 1'b0;
        fft_ready_i = 1'b0;
        #1;
        chk("rst_start", start_o, 0);
        chk("rst_x_re", x_re_o, 0);
        chk("rst_x_im", x_im_o, 0);
        chk("rst_cnt", frame_cnt_o, 0);
        chk("rst_ready", s_ready_o, 1);
        tick(2);
        rstn     = 1'b1;
        cnt_base = '0;
        tick(1);
    endtask

    int t1_exp [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int t4_exp [N] = '{100, 104, 102, 106, 101, 105, 103, 107};

    initial begin
        int la;
        int fc;
        int t0;
        int k;

        // single frame
        do_reset();
        for (int i = 0; i < N; i++) send(DW'(i), '0);
        la = last_acc;
        wait_bursts(1);
        chk("t1_latency", rise_cyc - la, 2);
        for (int i = 0; i < N; i++) chk("t1_order", last_re[i], t1_exp[i]);
        chk("t1_hold", x_re_o, 7);
        chk("t1_cnt", frame_cnt_o, 1);

        // backpressure, three frames
        do_reset();
        for (int i = 0; i < N; i++) send(DW'(10 + i), DW'(200 + i));
        for (int i = 0; i < N; i++) send(DW'(20 + i), DW'(210 + i));
        chk("t2_ready_drop", s_ready_o, 0);
        for (int i = 0; i < N; i++) send(DW'(30 + i), DW'(220 + i));
        tick(20);
        chk("t2_ready_stuck", s_ready_o, 0);
        chk("t2_no_launch", bursts, 1);
        chk("t2_start_low", start_o, 0);
        pulse_ready(fc);
        wait_bursts(2);
        chk("t2_fall_to_start", rise_cyc - fc, 3);
        pulse_ready(fc);
        wait_bursts(3);
        chk("t2_fall_to_start3", rise_cyc - fc, 3);
        chk("t2_cnt", frame_cnt_o, 3);

        // valid gaps, four frames
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                if (((i * 5 + f * 3) % 2) == 1) tick(1);
                send(DW'(16 * f + i + 32'h1000), DW'(32'h5000 - 16 * f - i));
            end
            la = last_acc;
            wait_bursts(f + 1);
            chk("t3_latency", rise_cyc - la, 2);
            pulse_ready(fc);
        end
        chk("t3_cnt", frame_cnt_o, 4);

        // reset in the middle of a burst
        do_reset();
        for (int i = 0; i < N; i++) send(DW'(50 + i), DW'(7));
        k = 0;
        while (!start_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t4_burst_seen", start_o, 1);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < N; i++) send(DW'(100 + i), '0);
        wait_bursts(1);
        for (int i = 0; i < N; i++) chk("t4_order", last_re[i], t4_exp[i]);
        chk("t4_cnt", frame_cnt_o, 1);

        // fill during drain, counter wrap
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        tick(1);
        release dut.frame_cnt_q;
        cnt_base = 16'hFFFF;
        chk("t5_preload", frame_cnt_o, 16'hFFFF);
        t0 = cyc;
        for (int i = 0; i < N; i++) send(DW'(300 + i), DW'(400 + i));
        la = last_acc;
        for (int i = 0; i < N; i++) send(DW'(310 + i), DW'(410 + i));
        chk("t5_f1_edges", la - t0, N);
        chk("t5_no_stall", last_acc - t0, 2 * N);
        wait_bursts(1);
        chk("t5_latency", rise_cyc - la, 2);
        tick(10);
        chk("t5_gap_bursts", bursts, 1);
        chk("t5_gap_start", start_o, 0);
        chk("t5_wrap", frame_cnt_o, 0);
        pulse_ready(fc);
        wait_bursts(2);
        chk("t5_fall_to_start", rise_cyc - fc, 3);
        chk("t5_cnt", frame_cnt_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
